// File: rtl/mem_access.sv
// Memory-access stage: turns CU load/store control into a req/ack data-RAM bus
// transaction, stalls the core until it ends, and returns the extended load result.
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word accesses are trapped instead of aligned down.
module mem_access #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cu_m2reg,
  input  logic        cu_wmem,
  input  logic [1:0]  cu_size,
  input  logic        cu_sext,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] ram_data,
  output logic        stall,
  output logic        mem_done,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     sd_q, sd_d;
  logic [1:0]      size_q, size_d;
  logic            sext_q, sext_d;
  logic            we_q, we_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            mis_q, mis_d;
  logic [31:0]     ram_q, ram_d;

  logic            start;
  logic            mis_in;
  logic [31:0]     rd_sh;
  logic [7:0]      rd_b;
  logic [15:0]     rd_h;
  logic [31:0]     rd_ext;
  logic [3:0]      be_lat;
  logic [31:0]     wd_lat;

  assign start = cu_m2reg | cu_wmem;

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis_in = ((cu_size == 2'b01) & addr[0]) | (cu_size[1] & (|addr[1:0]));
`else
  assign mis_in = 1'b0;
`endif

  // Load lane selection and extension from the latched access.
  always_comb begin
    rd_sh = bus_rdata >> {addr_q[1:0], 3'b000};
    rd_b  = rd_sh[7:0];
    rd_h  = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (size_q)
      2'b00:   rd_ext = {{24{sext_q & rd_b[7]}}, rd_b};
      2'b01:   rd_ext = {{16{sext_q & rd_h[15]}}, rd_h};
      default: rd_ext = bus_rdata;
    endcase
  end

  always_comb begin
    case (size_q)
      2'b00: begin
        be_lat = 4'b0001 << addr_q[1:0];
        wd_lat = {4{sd_q[7:0]}};
      end
      2'b01: begin
        be_lat = addr_q[1] ? 4'b1100 : 4'b0011;
        wd_lat = {2{sd_q[15:0]}};
      end
      default: begin
        be_lat = 4'b1111;
        wd_lat = sd_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sd_d    = sd_q;
    size_d  = size_q;
    sext_d  = sext_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    mis_d   = mis_q;
    ram_d   = ram_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          stall  = 1'b1;
          addr_d = addr;
          sd_d   = store_data;
          size_d = cu_size;
          sext_d = cu_sext;
          we_d   = cu_wmem;
          cnt_d  = '0;
          err_d  = 1'b0;
          mis_d  = mis_in;
          state_d = mis_in ? DONE : REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus_ack) begin
          if (!we_q) ram_d = rd_ext;
          cnt_d   = '0;
          state_d = DONE;
        end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          if (!we_q) ram_d = '0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        // CPU advances on this edge; held cu_* belong to the old instruction.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      sd_q    <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      ram_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sd_q    <= sd_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
      ram_q   <= ram_d;
    end
  end

  assign bus_req   = (state_q == REQ);
  assign bus_we    = bus_req & we_q;
  assign bus_addr  = bus_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus_be    = bus_req ? be_lat : 4'h0;
  assign bus_wdata = bus_req ? wd_lat : 32'h0;
  assign mem_done  = (state_q == DONE);
  assign bus_err   = mem_done & err_q;
  assign ram_data  = ram_q;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign  = mem_done & mis_q;
`else
  logic unused_mis;
  assign unused_mis = mis_in | mis_q;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Directed table-driven bench for mem_access with hand-computed expectations.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        cu_m2reg, cu_wmem, cu_sext;
  logic [1:0]  cu_size;
  logic [31:0] addr, store_data;
  logic [31:0] ram_data;
  logic        stall, mem_done, bus_err, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst),
    .cu_m2reg(cu_m2reg), .cu_wmem(cu_wmem), .cu_size(cu_size), .cu_sext(cu_sext),
    .addr(addr), .store_data(store_data), .ram_data(ram_data),
    .stall(stall), .mem_done(mem_done), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  typedef struct {
    logic        m2reg, wmem, sext;
    logic [1:0]  size;
    logic [31:0] addr, sd, rdata;
    int          waits;
    logic        noack;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wdata, exp_ram;
    int          exp_stalls, exp_reqs;
    logic        exp_err, exp_mis;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic m2reg, wmem, input logic [1:0] size, input logic sext,
                              input logic [31:0] a, sd, rdata, input int waits, input logic noack,
                              input logic exp_we, input logic [3:0] exp_be,
                              input logic [31:0] exp_addr, exp_wdata, exp_ram,
                              input int exp_stalls, exp_reqs, input logic exp_err, exp_mis);
    vec_t v;
    v.m2reg = m2reg; v.wmem = wmem; v.size = size; v.sext = sext;
    v.addr = a; v.sd = sd; v.rdata = rdata; v.waits = waits; v.noack = noack;
    v.exp_we = exp_we; v.exp_be = exp_be; v.exp_addr = exp_addr; v.exp_wdata = exp_wdata;
    v.exp_ram = exp_ram; v.exp_stalls = exp_stalls; v.exp_reqs = exp_reqs;
    v.exp_err = exp_err; v.exp_mis = exp_mis;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int stalls = 0, reqs = 0, dones = 0;
    logic       got = 1'b0, err = 1'b0, mis = 1'b0;
    logic       c_we = 1'b0;
    logic [3:0] c_be = '0;
    logic [31:0] c_addr = '0, c_wd = '0;
    string p;
    p = $sformatf("v%0d", idx);
    @(negedge clk);
    cu_m2reg = v.m2reg; cu_wmem = v.wmem; cu_size = v.size; cu_sext = v.sext;
    addr = v.addr; store_data = v.sd; bus_ack = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      if (bus_req) begin
        reqs++;
        if (reqs == 1) begin
          c_we = bus_we; c_be = bus_be; c_addr = bus_addr; c_wd = bus_wdata;
        end
        bus_ack   = !v.noack && (reqs > v.waits);
        bus_rdata = v.rdata;
      end else begin
        bus_ack = 1'b0;
      end
      #1;
      if (stall) stalls++;
      if (mem_done) begin
        dones++; got = 1'b1; err = bus_err;
`ifdef MEM_MISALIGN_TRAP_EN
        mis = misalign;
`endif
        cu_m2reg = 1'b0; cu_wmem = 1'b0; bus_ack = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    if (!got) begin
      failures++;
      checks++;
      $display("FAIL %s_done_timeout: no mem_done within cycle budget", p);
      cu_m2reg = 1'b0; cu_wmem = 1'b0; bus_ack = 1'b0;
    end
    check({p, "_reqs"}, reqs, v.exp_reqs);
    check({p, "_stalls"}, stalls, v.exp_stalls);
    check({p, "_err"}, {31'd0, err}, {31'd0, v.exp_err});
    if (v.exp_reqs > 0) begin
      check({p, "_we"}, {31'd0, c_we}, {31'd0, v.exp_we});
      check({p, "_be"}, {28'd0, c_be}, {28'd0, v.exp_be});
      check({p, "_addr"}, c_addr, v.exp_addr);
      check({p, "_wdata"}, c_wd, v.exp_wdata);
    end
`ifdef MEM_MISALIGN_TRAP_EN
    check({p, "_mis"}, {31'd0, mis}, {31'd0, v.exp_mis});
`endif
    @(negedge clk);
    #1;
    check({p, "_ram"}, ram_data, v.exp_ram);
    check({p, "_no_redone"}, {31'd0, mem_done}, 32'd0);
  endtask

  initial begin
    logic seen;
    rst = 1'b1; cu_m2reg = 0; cu_wmem = 0; cu_size = 0; cu_sext = 0;
    addr = 0; store_data = 0; bus_ack = 0; bus_rdata = 0;

    //      m2 wm size sx addr          sd            rdata        w  na  we be       addr          wdata         ram          st rq er mis
    vecs[0] = mk(1, 0, 2'b10, 0, 32'h0000_0100, 32'h0,        32'h1234_5678, 2, 0, 0, 4'b1111, 32'h0000_0100, 32'h0,        32'h1234_5678, 4, 3, 0, 0);
    vecs[1] = mk(1, 0, 2'b00, 1, 32'h0000_0103, 32'h0,        32'h80FF_7F01, 0, 0, 0, 4'b1000, 32'h0000_0100, 32'h0,        32'hFFFF_FF80, 2, 1, 0, 0);
    vecs[2] = mk(1, 0, 2'b00, 0, 32'h0000_0103, 32'h0,        32'h80FF_7F01, 0, 0, 0, 4'b1000, 32'h0000_0100, 32'h0,        32'h0000_0080, 2, 1, 0, 0);
    vecs[3] = mk(0, 1, 2'b01, 0, 32'h0000_0202, 32'hAAAA_BEEF, 32'h5555_5555, 1, 0, 1, 4'b1100, 32'h0000_0200, 32'hBEEF_BEEF, 32'h0000_0080, 3, 2, 0, 0);
    vecs[4] = mk(1, 0, 2'b01, 1, 32'h0000_0200, 32'h0,        32'h1234_8001, 0, 0, 0, 4'b0011, 32'h0000_0200, 32'h0,        32'hFFFF_8001, 2, 1, 0, 0);
    vecs[5] = mk(1, 0, 2'b00, 1, 32'h0000_0101, 32'h0,        32'h80FF_7F01, 0, 0, 0, 4'b0010, 32'h0000_0100, 32'h0,        32'h0000_007F, 2, 1, 0, 0);
    vecs[6] = mk(0, 1, 2'b00, 0, 32'h0000_0001, 32'h0000_00A5, 32'h0,       0, 0, 1, 4'b0010, 32'h0000_0000, 32'hA5A5_A5A5, 32'h0000_007F, 2, 1, 0, 0);
    vecs[7] = mk(1, 1, 2'b11, 1, 32'h0000_0300, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0, 0, 1, 4'b1111, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0000_007F, 2, 1, 0, 0);
    vecs[8] = mk(1, 0, 2'b10, 0, 32'h0000_0400, 32'h0,        32'h0,         0, 1, 0, 4'b1111, 32'h0000_0400, 32'h0,        32'h0000_0000, 17, 16, 1, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    vecs[9] = mk(1, 0, 2'b10, 0, 32'h0000_0101, 32'h0,        32'hCAFE_F00D, 0, 0, 0, 4'b0000, 32'h0,         32'h0,        32'h0000_0000, 1, 0, 0, 1);
`else
    vecs[9] = mk(1, 0, 2'b10, 0, 32'h0000_0101, 32'h0,        32'hCAFE_F00D, 0, 0, 0, 4'b1111, 32'h0000_0100, 32'h0,        32'hCAFE_F00D, 2, 1, 0, 0);
`endif

    repeat (2) @(negedge clk);
    #1;
    check("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_mem_done", {31'd0, mem_done}, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    check("rst_ram_data", ram_data, 32'd0);
    check("rst_bus_be", {28'd0, bus_be}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // bus_ack while idle must not complete anything
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      if (mem_done || stall || bus_req) seen = 1'b1;
    end
    bus_ack = 1'b0;
    check("idle_ack_ignored", {31'd0, seen}, 32'd0);
    check("idle_ack_ram", ram_data, vecs[9].exp_ram);

    // async reset in the middle of a request
    @(negedge clk);
    cu_m2reg = 1'b1; cu_size = 2'b10; addr = 32'h0000_0500;
    @(negedge clk);
    #1;
    check("midrst_req_before", {31'd0, bus_req}, 32'd1);
    rst = 1'b1; cu_m2reg = 1'b0;
    #1;
    check("midrst_bus_req", {31'd0, bus_req}, 32'd0);
    check("midrst_stall", {31'd0, stall}, 32'd0);
    check("midrst_ram", ram_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      if (mem_done) seen = 1'b1;
    end
    check("midrst_no_done", {31'd0, seen}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
